actuated_traffic_controller: RTL and testbench
==============================================

# actuated_traffic_controller

Parametrised, sensor-actuated two-road intersection controller: successor to the fixed-timing NS/EW sequencer. All phase durations are parameters. It adds an EW vehicle sensor with min/max green extension, an optional pedestrian walk phase, and a night flashing mode. It sits at the top of the intersection design and drives the NS and EW lamp drivers directly.

## Interface
- CNT_W, 6: phase counter width; every duration parameter must be ≤ 2^CNT_W.
- NS_MIN, 8: minimum NS green cycles.
- NS_MAX, 32: maximum NS green cycles (≥ NS_MIN).
- EW_MIN, 4: minimum EW green cycles.
- EW_MAX, 12: maximum EW green cycles (≥ EW_MIN).
- YEL_T, 2: yellow cycles, both roads.
- AR_T, 1: all-red clearance cycles.
- PED_T, 6: walk cycles.
- FLASH_T, 4: flash half-period in cycles.
- All durations are ≥ 1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ew_sensor  in  1  EW vehicle present (level).
- ped_req  in  1  pedestrian button (pulse or level).
- flash  in  1  request flashing mode (level).
- NS_light  out  2  RED=00, YELLOW=01, GREEN=10, OFF=11.
- EW_light  out  2  same encoding.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state code, registered.

## Operation
- States and codes: NS_GREEN 0, NS_YELLOW 1, ALL_RED_A 2, EW_GREEN 3, EW_YELLOW 4, ALL_RED_B 5, PED_WALK 6, FLASH 7.
- One phase counter, cleared to 0 on every state entry and incremented each cycle. "count = N−1" means N cycles spent in the state.
- NS_GREEN (NS=GREEN, EW=RED): exit to NS_YELLOW when (count ≥ NS_MIN−1 and (ew_pending or ew_sensor)) or count = NS_MAX−1.
- NS_YELLOW (NS=YELLOW, EW=RED): lasts YEL_T cycles, then ALL_RED_A.
- ALL_RED_A (both RED): lasts AR_T cycles, then FLASH if flash=1, else EW_GREEN.
- EW_GREEN (NS=RED, EW=GREEN): exit when (count ≥ EW_MIN−1 and ew_sensor=0) or count = EW_MAX−1. Sensor high extends green.
- EW_YELLOW (NS=RED, EW=YELLOW): lasts YEL_T cycles, then ALL_RED_B.
- ALL_RED_B (both RED): lasts AR_T cycles. Next state by priority: FLASH if flash=1; else PED_WALK if ped_pending (macro on); else NS_GREEN.
- PED_WALK (both RED, walk=1): lasts PED_T cycles, then NS_GREEN.
- FLASH:
  - Entered with NS=YELLOW, EW=RED.
  - Every FLASH_T cycles both lights toggle together to OFF and back.
  - When flash=0, go to ALL_RED_B on the next edge.
- ew_pending: sticky; set when ew_sensor=1 in any state except EW_GREEN; cleared on entry to EW_GREEN. Clear wins over a simultaneous set.
- ped_pending: sticky; set by ped_req=1; cleared on entry to PED_WALK. A request in the entry cycle is absorbed. Requests that arrive during FLASH are retained.
- Reset values: phase=0 (NS_GREEN), NS_light=GREEN, EW_light=RED, walk=0, counter=0, ew_pending=0, ped_pending=0.
- Reset asserted mid-phase overrides everything at the next edge.

## Timing
- All outputs are registered. Lights, walk and phase change on the same edge as the state transition; there is no combinational path from input to output.
- An input sampled at edge k affects outputs at edge k+1 at the earliest.
- Default cycle with no inputs: 32+2+1+4+2+1 = 42 cycles.

## Configuration
- TLC_PED_WALK_EN defined:
  - ped_pending and PED_WALK are implemented as above.
- TLC_PED_WALK_EN undefined:
  - ped_req is ignored and walk is tied to 0.
  - PED_WALK is not generated; ALL_RED_B goes to FLASH or NS_GREEN only.
  - Phase code 6 never appears.

## Structure
- Package tlc_pkg holds:
  - light encoding constants RED, YELLOW, GREEN, OFF;
  - the 3-bit state enum typedef with the codes above.
- Sub-module tlc_phase_timer: CNT_W counter with synchronous clear-on-entry, increment, and terminal compare against a runtime-selected limit. It is instantiated once for phase timing; the flash toggle reuses it.

## Test plan
All cases use default parameters.
- Reset, all inputs 0 → NS GREEN 32, NS YELLOW 2, all-red 1, EW GREEN 4, EW YELLOW 2, all-red 1; phase sequence 0,1,2,3,4,5,0 with a 42-cycle period.
- ew_sensor pulse at cycle 3 of NS_GREEN → NS GREEN lasts exactly 8 cycles; ew_pending clears on EW_GREEN entry.
- ew_sensor held high through EW_GREEN → EW GREEN lasts 12 cycles. Sensor dropping at cycle 6 → EW GREEN lasts 7 cycles.
- ped_req pulse during EW_GREEN:
  - macro on → after ALL_RED_B, walk=1 with both RED for 6 cycles, then NS_GREEN;
  - macro off → straight to NS_GREEN with walk=0.
- flash=1 asserted in NS_GREEN → normal exit to NS_YELLOW and ALL_RED_A, then FLASH. Lights go YELLOW/RED then OFF/OFF every 4 cycles. flash=0 → one ALL_RED_B cycle, then NS_GREEN.
- rst=1 for one cycle mid EW_YELLOW with ped_pending set → next edge: phase=0, NS=GREEN, EW=RED, walk=0, pendings cleared.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared lamp encodings and phase codes for the actuated traffic controller.
package tlc_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] OFF    = 2'b11;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } tlc_state_e;

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase counter: clears on request, otherwise counts up; done when count hits
// the limit selected by the caller (limit = duration - 1).
module tlc_phase_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else              count <= count + CNT_W'(1);
  end

  assign done = (count == limit);

endmodule

// File: rtl/actuated_traffic_controller.sv
// Sensor-actuated NS/EW intersection controller with night flash mode.
// Optional pedestrian walk phase enabled by defining TLC_PED_WALK_EN.
module actuated_traffic_controller
  import tlc_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int NS_MIN  = 8,
  parameter int NS_MAX  = 32,
  parameter int EW_MIN  = 4,
  parameter int EW_MAX  = 12,
  parameter int YEL_T   = 2,
  parameter int AR_T    = 1,
  parameter int PED_T   = 6,
  parameter int FLASH_T = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ew_sensor,
  input  logic       ped_req,
  input  logic       flash,
  output logic [1:0] NS_light,
  output logic [1:0] EW_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] NS_MIN_T = CNT_W'(NS_MIN - 1);
  localparam logic [CNT_W-1:0] NS_MAX_T = CNT_W'(NS_MAX - 1);
  localparam logic [CNT_W-1:0] EW_MIN_T = CNT_W'(EW_MIN - 1);
  localparam logic [CNT_W-1:0] EW_MAX_T = CNT_W'(EW_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_L    = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] AR_L     = CNT_W'(AR_T - 1);
  localparam logic [CNT_W-1:0] PED_L    = CNT_W'(PED_T - 1);
  localparam logic [CNT_W-1:0] FLASH_L  = CNT_W'(FLASH_T - 1);

  tlc_state_e       state, next_state;
  logic [CNT_W-1:0] limit, count;
  logic             done, tmr_clear, entering;
  logic             flash_off, flash_off_nx;
  logic             ew_pending;
  logic [1:0]       ns_nx, ew_nx;
  logic             walk_nx;

`ifdef TLC_PED_WALK_EN
  logic ped_pending;

  always_ff @(posedge clk) begin
    if (rst)                                          ped_pending <= 1'b0;
    else if (next_state == PED_WALK && state != PED_WALK) ped_pending <= 1'b0;
    else if (ped_req)                                 ped_pending <= 1'b1;
  end
`else
  logic ped_unused;
  assign ped_unused = ped_req;
`endif

  // Flash mode reuses the phase timer as its half-period divider.
  tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .limit (limit),
    .count (count),
    .done  (done)
  );

  always_comb begin
    limit = '0;
    case (state)
      NS_GREEN:            limit = NS_MAX_T;
      NS_YELLOW, EW_YELLOW: limit = YEL_L;
      ALL_RED_A, ALL_RED_B: limit = AR_L;
      EW_GREEN:            limit = EW_MAX_T;
      PED_WALK:            limit = PED_L;
      FLASH:               limit = FLASH_L;
      default:             limit = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      NS_GREEN:  if ((count >= NS_MIN_T && (ew_pending || ew_sensor)) || done) next_state = NS_YELLOW;
      NS_YELLOW: if (done) next_state = ALL_RED_A;
      ALL_RED_A: if (done) next_state = flash ? FLASH : EW_GREEN;
      EW_GREEN:  if ((count >= EW_MIN_T && !ew_sensor) || done) next_state = EW_YELLOW;
      EW_YELLOW: if (done) next_state = ALL_RED_B;
      ALL_RED_B: if (done) begin
        if (flash) next_state = FLASH;
`ifdef TLC_PED_WALK_EN
        else if (ped_pending) next_state = PED_WALK;
`endif
        else next_state = NS_GREEN;
      end
      PED_WALK:  if (done) next_state = NS_GREEN;
      FLASH:     if (!flash) next_state = ALL_RED_B;
      default:   next_state = NS_GREEN;
    endcase
  end

  // Lamps are decoded from the next state so they switch on the transition edge.
  always_comb begin
    entering     = (next_state != state);
    tmr_clear    = entering || (state == FLASH && done);
    flash_off_nx = (state == FLASH && !entering) ? (flash_off ^ done) : 1'b0;
    ns_nx        = RED;
    ew_nx        = RED;
    walk_nx      = 1'b0;
    case (next_state)
      NS_GREEN:  ns_nx = GREEN;
      NS_YELLOW: ns_nx = YELLOW;
      EW_GREEN:  ew_nx = GREEN;
      EW_YELLOW: ew_nx = YELLOW;
      FLASH: begin
        if (flash_off_nx) begin
          ns_nx = OFF;
          ew_nx = OFF;
        end else begin
          ns_nx = YELLOW;
        end
      end
      default: ;
    endcase
`ifdef TLC_PED_WALK_EN
    walk_nx = (next_state == PED_WALK);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NS_GREEN;
      flash_off  <= 1'b0;
      ew_pending <= 1'b0;
      NS_light   <= GREEN;
      EW_light   <= RED;
      walk       <= 1'b0;
    end else begin
      state     <= next_state;
      flash_off <= flash_off_nx;
      NS_light  <= ns_nx;
      EW_light  <= ew_nx;
      walk      <= walk_nx;
      if (next_state == EW_GREEN && state != EW_GREEN) ew_pending <= 1'b0;
      else if (state != EW_GREEN && ew_sensor)         ew_pending <= 1'b1;
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_actuated_traffic_controller.sv
// Self-checking bench: directed phase-duration scenarios plus randomized
// inputs against a rule-level reference model.
module tb_actuated_traffic_controller;

  localparam int NS_MIN = 8, NS_MAX = 32, EW_MIN = 4, EW_MAX = 12;
  localparam int YEL_T = 2, AR_T = 1, PED_T = 6, FLASH_T = 4;
`ifdef TLC_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, ew_sensor = 1'b0, ped_req = 1'b0, flash = 1'b0;
  logic [1:0] NS_light, EW_light;
  logic       walk;
  logic [2:0] phase;

  int checks = 0, errors = 0;
  int m_ph = 0, m_el = 0;
  bit m_ewp = 1'b0, m_pedp = 1'b0;

  always #5 clk = ~clk;

  actuated_traffic_controller dut (
    .clk(clk), .rst(rst), .ew_sensor(ew_sensor), .ped_req(ped_req), .flash(flash),
    .NS_light(NS_light), .EW_light(EW_light), .walk(walk), .phase(phase)
  );

  // Flash lamps are lit for the first FLASH_T cycles of every 2*FLASH_T.
  function automatic logic [1:0] exp_ns(input int ph, input int el);
    case (ph)
      0:       return 2'b10;
      1:       return 2'b01;
      7:       return ((el / FLASH_T) % 2 == 0) ? 2'b01 : 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_ew(input int ph, input int el);
    case (ph)
      3:       return 2'b10;
      4:       return 2'b01;
      7:       return ((el / FLASH_T) % 2 == 0) ? 2'b00 : 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step();
    int nx;
    int d;
    nx = m_ph;
    d  = m_el + 1;
    case (m_ph)
      0: if ((d >= NS_MIN && (m_ewp || ew_sensor)) || d == NS_MAX) nx = 1;
      1: if (d == YEL_T) nx = 2;
      2: if (d == AR_T) nx = flash ? 7 : 3;
      3: if ((d >= EW_MIN && !ew_sensor) || d == EW_MAX) nx = 4;
      4: if (d == YEL_T) nx = 5;
      5: if (d == AR_T) nx = flash ? 7 : ((PED_EN && m_pedp) ? 6 : 0);
      6: if (d == PED_T) nx = 0;
      default: if (!flash) nx = 5;
    endcase
    m_ewp = (nx == 3 && m_ph != 3) ? 1'b0 : (m_ewp || (m_ph != 3 && ew_sensor));
    m_pedp = (nx == 6 && m_ph != 6) ? 1'b0 : (m_pedp || (PED_EN && ped_req));
    m_el = (nx != m_ph) ? 0 : m_el + 1;
    m_ph = nx;
  endtask

  task automatic cycle(input bit e, input bit p, input bit f);
    ew_sensor = e;
    ped_req   = p;
    flash     = f;
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_el = 0; m_ewp = 1'b0; m_pedp = 1'b0;
    end else begin
      model_step();
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rst = 1'b0;
  endtask

  // Stays in phase `code` while it lasts (bounded); sensor high for len in [e_from,e_to).
  task automatic measure(input int code, input int e_from, input int e_to, input int p_at,
                         input bit f, output int len);
    len = 0;
    while (phase == 3'(code) && len < 200) begin
      cycle(len >= e_from && len < e_to, len == p_at, f);
      len++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (phase !== 3'd0)     begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
    checks++; if (NS_light !== 2'b10) begin errors++; $display("FAIL reset_ns got %b want 10", NS_light); end
    checks++; if (EW_light !== 2'b00) begin errors++; $display("FAIL reset_ew got %b want 00", EW_light); end
    checks++; if (walk !== 1'b0)      begin errors++; $display("FAIL reset_walk got %b want 0", walk); end
  endtask

  task automatic test_default_cycle();
    int dur[6];
    int len;
    int total;
    dur = '{32, 2, 1, 4, 2, 1};
    total = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++; if (phase !== 3'(i)) begin errors++; $display("FAIL seq_phase got %0d want %0d", phase, i); end
      measure(i, 0, 0, -1, 0, len);
      total += len;
      checks++; if (len !== dur[i]) begin errors++; $display("FAIL dur_phase%0d got %0d want %0d", i, len, dur[i]); end
    end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL wrap_phase got %0d want 0", phase); end
    checks++; if (total !== 42)   begin errors++; $display("FAIL period got %0d want 42", total); end
  endtask

  task automatic test_ew_sensor();
    int len;
    do_reset();
    measure(0, 2, 3, -1, 0, len);
    checks++; if (len !== 8) begin errors++; $display("FAIL ns_min_ext got %0d want 8", len); end
    measure(1, 0, 0, -1, 0, len);
    measure(2, 0, 0, -1, 0, len);
    measure(3, 0, 1000, -1, 0, len);
    checks++; if (len !== 12) begin errors++; $display("FAIL ew_max got %0d want 12", len); end
    measure(4, 0, 0, -1, 0, len);
    measure(5, 0, 0, -1, 0, len);
    measure(0, 0, 0, -1, 0, len);
    checks++; if (len !== 32) begin errors++; $display("FAIL ew_pend_clr got %0d want 32", len); end
    measure(1, 0, 0, -1, 0, len);
    measure(2, 0, 0, -1, 0, len);
    measure(3, 0, 6, -1, 0, len);
    checks++; if (len !== 7) begin errors++; $display("FAIL ew_drop got %0d want 7", len); end
  endtask

  task automatic test_ped();
    int len;
    do_reset();
    for (int i = 0; i < 3; i++) measure(i, 0, 0, -1, 0, len);
    measure(3, 0, 0, 1, 0, len);
    measure(4, 0, 0, -1, 0, len);
    measure(5, 0, 0, -1, 0, len);
    checks++; if (phase !== (PED_EN ? 3'd6 : 3'd0)) begin errors++; $display("FAIL ped_phase got %0d want %0d", phase, PED_EN ? 6 : 0); end
    checks++; if (walk !== PED_EN) begin errors++; $display("FAIL ped_walk got %b want %b", walk, PED_EN); end
    checks++; if (NS_light !== (PED_EN ? 2'b00 : 2'b10) || EW_light !== 2'b00) begin
      errors++; $display("FAIL ped_lamps got %b/%b", NS_light, EW_light);
    end
    measure(6, 0, 0, -1, 0, len);
    checks++; if (len !== (PED_EN ? PED_T : 0)) begin errors++; $display("FAIL ped_len got %0d want %0d", len, PED_EN ? PED_T : 0); end
    checks++; if (phase !== 3'd0 || walk !== 1'b0) begin errors++; $display("FAIL ped_after got %0d/%b want 0/0", phase, walk); end
  endtask

  task automatic test_flash();
    int len;
    logic [3:0] exp;
    do_reset();
    measure(0, 0, 0, -1, 1, len);
    checks++; if (len !== 32) begin errors++; $display("FAIL flash_ns got %0d want 32", len); end
    measure(1, 0, 0, -1, 1, len);
    measure(2, 0, 0, -1, 1, len);
    checks++; if (phase !== 3'd7) begin errors++; $display("FAIL flash_enter got %0d want 7", phase); end
    for (int c = 0; c < 16; c++) begin
      exp = ((c / 4) % 2 == 0) ? 4'b0100 : 4'b1111;
      checks++; if ({NS_light, EW_light} !== exp) begin
        errors++; $display("FAIL flash_lamps c=%0d got %b want %b", c, {NS_light, EW_light}, exp);
      end
      cycle(0, 0, 1);
    end
    cycle(0, 0, 0);
    checks++; if (phase !== 3'd5 || {NS_light, EW_light} !== 4'b0000) begin
      errors++; $display("FAIL flash_exit got %0d %b want 5 0000", phase, {NS_light, EW_light});
    end
    cycle(0, 0, 0);
    checks++; if (phase !== 3'd0 || {NS_light, EW_light} !== 4'b1000) begin
      errors++; $display("FAIL flash_resume got %0d %b want 0 1000", phase, {NS_light, EW_light});
    end
  endtask

  task automatic test_reset_mid();
    int len;
    do_reset();
    for (int i = 0; i < 3; i++) measure(i, 0, 0, -1, 0, len);
    measure(3, 0, 0, 1, 0, len);
    cycle(1, 0, 0);
    rst = 1'b1;
    cycle(0, 0, 0);
    rst = 1'b0;
    checks++; if (phase !== 3'd0 || NS_light !== 2'b10 || EW_light !== 2'b00 || walk !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %0d %b %b %b want 0 10 00 0", phase, NS_light, EW_light, walk);
    end
    measure(0, 0, 0, -1, 0, len);
    checks++; if (len !== 32) begin errors++; $display("FAIL mid_ewp got %0d want 32", len); end
    for (int i = 1; i < 6; i++) measure(i, 0, 0, -1, 0, len);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL mid_pedp got %0d want 0", phase); end
  endtask

  task automatic test_random();
    bit f_lvl;
    logic [7:0] exp;
    f_lvl = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) f_lvl = ~f_lvl;
      rst = ($urandom_range(0, 399) == 0);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, f_lvl);
      exp = {3'(m_ph), exp_ns(m_ph, m_el), exp_ew(m_ph, m_el), m_ph == 6};
      checks++; if ({phase, NS_light, EW_light, walk} !== exp) begin
        errors++; $display("FAIL random i=%0d got %b want %b", i, {phase, NS_light, EW_light, walk}, exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_ew_sensor();
    test_ped();
    test_flash();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
